// File: rtl/msk_pkg.sv
// Shared helpers for the masked-pipeline blocks.
//   clog2     : ceiling log2, usable in parameter/localparam expressions
//   share_idx : flat bit position of share k of sharing j in a word of
//               sharings that each carry d shares (layout [j*d +: d])
package msk_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int p = 1; p < n; p = p * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int share_idx(input int j, input int k, input int d);
    return j * d + k;
  endfunction

endpackage

// File: rtl/msk_pipe_stage.sv
// One slot of the masked elastic pipeline: a valid flop plus an enabled
// share register.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (clears the valid flop only)
//   load      : capture in into the share register
//   valid_in  : valid bit of the upstream slot (or the block input)
//   adv       : slot may advance; valid flop takes valid_in
//   in        : count*d shares from upstream
//   valid_out : slot holds a word
//   out       : registered shares of this slot
module msk_pipe_stage
  import msk_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               valid_in,
  input  logic               adv,
  input  logic [count*d-1:0] in,
  output logic               valid_out,
  output logic [count*d-1:0] out
);

  logic r_valid;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (adv) begin
      r_valid <= valid_in;
    end
  end

  assign valid_out = r_valid;

  // Every share gets its own flop so nothing downstream of synthesis can
  // merge two shares of a sharing into shared logic.
  for (genvar j = 0; j < count; j++) begin : g_sharing
    for (genvar k = 0; k < d; k++) begin : g_share
      (* keep = "true", preserve = "true" *) logic r_share;

      // NOTE: share registers are deliberately left out of reset; validity is
      // carried by r_valid alone and clearing shares would only add a
      // value-independent but pointless load path.
      always_ff @(posedge clk) begin
        if (load) begin
          r_share <= in[share_idx(j, k, d)];
        end
      end

      assign out[share_idx(j, k, d)] = r_share;
    end
  end

endmodule

// File: rtl/msk_pipe_reg.sv
// Elastic pipeline of `depth` register slots for masked sharings with
// valid/ready handshaking, bubble collapsing and an occupancy counter.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (drops all buffered words)
//   in_valid  : upstream word present
//   in_ready  : block accepts `in` this cycle
//   in        : count sharings of d shares, sharing j at [j*d +: d]
//   out_valid : output slot holds a word
//   out_ready : downstream accepts `out` this cycle
//   out       : output slot contents, same layout as `in`
//   occupancy : number of occupied slots, 0..depth
module msk_pipe_reg
  import msk_pkg::*;
#(
  parameter  int d     = 2,
  parameter  int count = 1,
  parameter  int depth = 2,
  localparam int OW    = clog2(depth + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [count*d-1:0] in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [count*d-1:0] out,
  output logic [OW-1:0]      occupancy
);

  localparam int W = count * d;

  logic [depth-1:0] w_v;
  logic [depth:0]   w_rdy;
  logic [W-1:0]     w_s [depth];
  logic             w_accept;
  logic             w_emit;
  logic [OW-1:0]    r_occ;

  // Ready ripples from the output back to the input in one cycle, so a full
  // pipeline can take a new word in the same cycle its output drains.
  // NOTE: every bit is given a value on every pass, so no latch is inferred.
  always_comb begin
    w_rdy        = '0;
    w_rdy[depth] = out_ready;
    for (int i = depth - 1; i >= 0; i--) begin
      w_rdy[i] = !w_v[i] || w_rdy[i+1];
    end
  end

  for (genvar i = 0; i < depth; i++) begin : g_stage
    logic         w_vprev;
    logic [W-1:0] w_sprev;

    if (i == 0) begin : g_head
      assign w_vprev = in_valid;
      assign w_sprev = in;
    end else begin : g_body
      assign w_vprev = w_v[i-1];
      assign w_sprev = w_s[i-1];
    end

    // Data enable is built from control bits only, never from share values.
    msk_pipe_stage #(
      .d     (d),
      .count (count)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .load      (w_rdy[i] && w_vprev),
      .valid_in  (w_vprev),
      .adv       (w_rdy[i]),
      .in        (w_sprev),
      .valid_out (w_v[i]),
      .out       (w_s[i])
    );
  end

  assign in_ready  = w_rdy[0] && !rst;
  assign out_valid = w_v[depth-1] && !rst;
  assign out       = w_s[depth-1];

  assign w_accept = in_valid && in_ready;
  assign w_emit   = out_valid && out_ready;

  // Tracks popcount of the valid bits; accept and emit together cancel, and
  // flow control keeps it inside 0..depth so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else if (w_accept && !w_emit) begin
      r_occ <= r_occ + OW'(1);
    end else if (!w_accept && w_emit) begin
      r_occ <= r_occ - OW'(1);
    end
  end

  assign occupancy = r_occ;

endmodule

// File: doc/msk_pipe_reg.md
# msk_pipe_reg

Parametrised elastic pipeline for masked sharings: `depth` register stages, each carrying `count` sharings of `d` shares, with valid/ready flow control, bubble collapsing and an occupancy count. It sits between masked gadgets wherever a latency-balancing or decoupling delay must tolerate back-pressure. No logic ever combines shares of the same sharing. Share registers carry keep/preserve attributes so synthesis cannot merge or optimise them.

## Interface
- `d`, 2, number of shares per sharing (≥1)
- `count`, 1, number of sharings per word (≥1)
- `depth`, 2, number of register stages (≥1)
- `OW`, derived `$clog2(depth+1)`, occupancy width (localparam)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream word present
- `in_ready`  out  1  block accepts `in` this cycle
- `in`  in  count*d  input sharings; bits [j*d +: d] are the d shares of sharing j
- `out_valid`  out  1  output-stage word present
- `out_ready`  in  1  downstream accepts `out` this cycle
- `out`  out  count*d  output-stage sharings, same layout as `in`
- `occupancy`  out  OW  number of valid stages, 0..depth

## Operation
- Stages are indexed 0 (input) to depth-1 (output). Each stage has a valid bit `v[i]` and a data register `s[i]`.
- Stage ready: `rdy[i] = !v[i] || rdy[i+1]`, with `rdy[depth] = out_ready`. This is a combinational chain, so a full pipeline accepts a new word in the same cycle the output drains.
- `in_ready = rdy[0] && !rst`.
- `out_valid = v[depth-1] && !rst`.
- `out = s[depth-1]`.
- Stage i update when `rdy[i]`:
  - `v[i] <= v_prev`, where `v_prev` is `v[i-1]`, or `in_valid` for stage 0.
  - If `v_prev` is also set, `s[i] <= s[i-1]`, or `in` for stage 0.
  - Otherwise `s[i]` holds.
- When `!rdy[i]`, the stage holds both valid and data.
- Data registers are never cleared, on reset or on drain. Their enable depends only on control bits, never on share values.
- `occupancy <= occupancy + accept - emit`:
  - `accept = in_valid && in_ready`
  - `emit = out_valid && out_ready`
  - It is a registered counter and always equals popcount(v).
- Ordering is strict FIFO. Words are never dropped or duplicated.

## Timing
- Reset: the edge with `rst=1` clears all `v[i]` and sets `occupancy=0`.
- While `rst` is high, `in_ready=0` and `out_valid=0`; no transfer occurs.
- After reset: `in_ready=1`, `out_valid=0`, `occupancy=0`. `out` holds stale contents (X after power-up). The bench must ignore `out` whenever `out_valid=0`.
- Latency: a word accepted at edge k into an empty pipeline gives `out_valid=1` after edge k+depth-1, i.e. depth cycles after it was presented.
- Throughput: 1 word/cycle when `out_ready=1`.
- Bubbles collapse: a stalled output stage does not stop upstream stages from filling empty slots.
- Full (occupancy=depth) with `out_ready=1`: `in_ready=1`. Simultaneous accept and emit leave occupancy unchanged.
- Full with `out_ready=0`: `in_ready=0` and all state holds.
- Empty with `in_valid=1`: `out_valid` stays 0 for depth-1 further edges. There is no bypass path.
- Reset mid-operation: buffered words are discarded and never re-emitted.
- The counter never wraps; depth is its maximum.

## Structure
- Shared package `msk_pkg`:
  - `clog2` helper function
  - share-index macro/function for `j*d + k`
- Sub-module `msk_pipe_stage` (params `d`, `count`):
  - ports: `clk`, `rst`, `load`, `valid_in`, `adv`, `in`, `valid_out`, `out`
  - contains one enabled share register and one valid flop
- `msk_pipe_reg` instantiates `depth` stages in a generate loop and holds the ready chain and occupancy counter.

## Test plan
- Reset (d=2, count=2, depth=3): `rst` high 2 cycles with `in_valid=1` → `in_ready=0` and `out_valid=0` throughout; after deassert `in_ready=1`, `occupancy=0`.
- Streaming with `out_ready=1`: present words 0x1, 0x2, 0x3, … every cycle from cycle 0 → first `out_valid` in cycle 3 with `out=0x1`, then one word per cycle in order; `occupancy` reaches 3 and stays there.
- Back-pressure with `out_ready=0`: push 0x5, 0xA, 0xC, 0xF → the first three are accepted and `in_ready=0` while 0xF waits; raise `out_ready` → `in_ready=1` the same cycle, 0xF is accepted, output order is 5, A, C, F.
- Bubble collapse: 0x9 accepted, stall 2 cycles, then 0x6 accepted while `out_ready=0` → 0x9 sits in stage 2 and 0x6 advances to stage 1; `occupancy=2`; release gives 9 then 6.
- Reset mid-operation with `occupancy=2`: one-cycle `rst` → next cycle `out_valid=0` and `occupancy=0`; the old words never appear on `out`.
- depth=1, full, `in_valid=1`, `out_ready=1` → accept and emit in the same cycle; `occupancy` stays 1 and `out` updates to the new word next cycle.
